game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter BIRD_DIV, default 4: clk cycles between bird_tick pulses.
REQ-002 SHALL have parameter PIPE_DIV, default 8: base clk cycles between pipe_tick pulses.
REQ-003 SHALL have parameter PIPE_STEP, default 2: pipe period reduction per level.
REQ-004 SHALL have parameter PIPE_MIN, default 4: floor on the pipe period.
REQ-005 SHALL have parameter SCORE_PER_LEVEL, default 2: score pulses per level increment.
REQ-006 SHALL have parameter CRASH_CYCLES, default 6: length of the CRASH state in clk cycles.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port flap, input, 1: level button, high while pressed.
REQ-010 SHALL have port collision, input, 1: level, high when the bird overlaps a pipe or hits the ground.
REQ-011 SHALL have port score_pulse, input, 1: one-cycle pulse for each pipe passed.
REQ-012 SHALL have port bird_tick, output, 1: one-cycle step enable for the bird column.
REQ-013 SHALL have port pipe_tick, output, 1: one-cycle shift enable for the pipe columns.
REQ-014 SHALL have port freeze, output, 1: high when datapath state must hold.
REQ-015 SHALL have port game_clear, output, 1: one-cycle pulse that reinitialises bird, pipes and score.
REQ-016 SHALL have port flash, output, 1: crash blink for the display.
REQ-017 SHALL have port state, output, 2: encoded as IDLE=0, PLAY=1, CRASH=2, OVER=3.
REQ-018 SHALL have port level, output, 3: current difficulty level.

Function
REQ-019 SHALL register flap and detect its rising edge (flap_rise); the edge takes effect one cycle after flap rises.
REQ-020 SHALL behave as follows in IDLE: freeze=1, ticks=0; on flap_rise go to PLAY, and clear both prescalers and level.
REQ-021 SHALL behave as follows in PLAY: freeze=0; if collision=1, go to CRASH the next cycle.
REQ-022 SHALL pulse bird_tick in PLAY for one cycle when the bird prescaler reaches BIRD_DIV-1, and wrap the prescaler to 0 on that cycle.
REQ-023 SHALL pulse pipe_tick in PLAY for one cycle when the pipe prescaler reaches P-1, where P = max(PIPE_DIV - level*PIPE_STEP, PIPE_MIN), and wrap the prescaler to 0 on that cycle.
REQ-024 SHALL take any change in P from the next prescaler wrap, and SHALL wrap immediately if the prescaler count is already at or above P-1.
REQ-025 SHALL count score_pulse only in PLAY; after every SCORE_PER_LEVEL counted pulses, level increments and saturates at 7.
REQ-026 SHALL give collision priority over score_pulse when both are high in the same cycle: the score pulse is not counted.
REQ-027 SHALL behave as follows in CRASH: freeze=1, ticks=0; a counter runs from 0 to CRASH_CYCLES-1, flash toggles every cycle starting at 1, and after the last count the block goes to OVER.
REQ-028 SHALL ignore flap_rise in CRASH.
REQ-029 SHALL behave as follows in OVER: freeze=1, flash=1 steady; on flap_rise, pulse game_clear for one cycle and go to IDLE.
REQ-030 SHALL treat collision as don't-care outside PLAY.
REQ-031 SHALL drive bird_tick, pipe_tick and game_clear only from registers (glitch-free).

Reset
REQ-032 SHALL, while reset=1, asynchronously force state=IDLE, freeze=1, game_clear=1, and bird_tick=pipe_tick=flash=0.
REQ-033 SHALL, while reset=1, clear level, the score sub-count, both prescalers, the crash counter and the flap register.
REQ-034 SHALL deassert game_clear on the first clock after reset falls.
REQ-035 SHALL allow reset in any state, including mid-CRASH, to abort immediately to IDLE with no further ticks.

Configuration
REQ-036 SHALL compile in difficulty speedup when SPEEDUP_EN is defined: level counting and P per REQ-023.
REQ-037 SHALL, when SPEEDUP_EN is undefined, tie level to 0, omit the score counter, and fix P = PIPE_DIV.

Verification
REQ-038 SHALL cover: reset, then flap high 1 cycle -> state=1 two cycles later; bird_tick every 4 cycles; pipe_tick every 8 cycles.
REQ-039 SHALL cover, with SPEEDUP_EN: 2 score pulses -> level=1 and pipe period 6; 6 more -> level=4 and period 4 (floor); 14 total -> level=7 and saturated.
REQ-040 SHALL cover: collision and score_pulse high together in PLAY -> state=2, level unchanged, no ticks thereafter.
REQ-041 SHALL cover: CRASH -> flash sequence 1,0,1,0,1,0, then state=3 with flash=1; flap during CRASH is ignored.
REQ-042 SHALL cover: OVER plus flap rise -> game_clear high exactly 1 cycle, then state=0.
REQ-043 SHALL cover: reset asserted mid-PLAY between clock edges -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: flappy-style game FSM with bird/pipe tick prescalers and crash blink.
// Define SPEEDUP_EN to enable score-driven difficulty levels that shorten the pipe period.
module game_sequencer #(
  parameter int BIRD_DIV        = 4,
  parameter int PIPE_DIV        = 8,
  parameter int PIPE_STEP       = 2,
  parameter int PIPE_MIN        = 4,
  parameter int SCORE_PER_LEVEL = 2,
  parameter int CRASH_CYCLES    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flap,
  input  logic       collision,
  input  logic       score_pulse,
  output logic       bird_tick,
  output logic       pipe_tick,
  output logic       freeze,
  output logic       game_clear,
  output logic       flash,
  output logic [1:0] state,
  output logic [2:0] level
);
  localparam int BW = $clog2(BIRD_DIV + 1);
  localparam int PW = $clog2(PIPE_DIV + PIPE_MIN + 1);
  localparam int CW = $clog2(CRASH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PLAY, CRASH, OVER} st_t;
  st_t st, st_nx;
  logic [1:0] flap_r;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] ccnt;
  logic flap_rise, play, start, b_wrap, p_wrap;
  int p_len;
  assign flap_rise = flap_r[0] & ~flap_r[1];
  // a colliding cycle is already treated as lost: no ticks, no score
  assign play   = st == PLAY && !collision;
  assign start  = st == IDLE && flap_rise;
  assign b_wrap = int'(bcnt) >= BIRD_DIV - 1;
  assign p_wrap = int'(pcnt) >= p_len - 1;
  assign state  = st;
  assign freeze = st != PLAY;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:  st_nx = flap_rise ? PLAY : IDLE;
      PLAY:  st_nx = collision ? CRASH : PLAY;
      CRASH: st_nx = int'(ccnt) == CRASH_CYCLES - 1 ? OVER : CRASH;
      OVER:  st_nx = flap_rise ? IDLE : OVER;
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flap_r     <= '0;
      bcnt       <= '0;
      pcnt       <= '0;
      ccnt       <= '0;
      bird_tick  <= 1'b0;
      pipe_tick  <= 1'b0;
      flash      <= 1'b0;
      game_clear <= 1'b1;
    end else begin
      flap_r     <= {flap_r[0], flap};
      bird_tick  <= play && b_wrap;
      pipe_tick  <= play && p_wrap;
      bcnt       <= start ? '0 : play ? (b_wrap ? '0 : bcnt + 1'b1) : bcnt;
      pcnt       <= start ? '0 : play ? (p_wrap ? '0 : pcnt + 1'b1) : pcnt;
      ccnt       <= st == CRASH ? ccnt + 1'b1 : '0;
      flash      <= st_nx == CRASH ? (st == CRASH ? ~flash : 1'b1) : st_nx == OVER;
      game_clear <= st == OVER && flap_rise;
    end
  end
`ifdef SPEEDUP_EN
  logic [$clog2(SCORE_PER_LEVEL + 1)-1:0] sc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc    <= '0;
      level <= '0;
    end else if (start) begin
      sc    <= '0;
      level <= '0;
    end else if (play && score_pulse) begin
      sc    <= int'(sc) == SCORE_PER_LEVEL - 1 ? '0 : sc + 1'b1;
      level <= int'(sc) == SCORE_PER_LEVEL - 1 && level != 3'd7 ? level + 1'b1 : level;
    end
  end
  assign p_len = PIPE_DIV - int'(level) * PIPE_STEP < PIPE_MIN ? PIPE_MIN
               : PIPE_DIV - int'(level) * PIPE_STEP;
`else
  logic unused_score;
  assign unused_score = score_pulse;
  assign level = '0;
  assign p_len = PIPE_DIV;
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game_sequencer with default parameters.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset, flap, collision, score_pulse;
  logic bird_tick, pipe_tick, freeze, game_clear, flash;
  logic [1:0] state;
  logic [2:0] level;
  int checks = 0, failures = 0;
`ifdef SPEEDUP_EN
  localparam int L1 = 1, L4 = 4, L7 = 7, P1 = 6, P4 = 4;
`else
  localparam int L1 = 0, L4 = 0, L7 = 0, P1 = 8, P4 = 8;
`endif
  always #5 clk = ~clk;
  game_sequencer dut (
    .clk(clk), .reset(reset), .flap(flap), .collision(collision), .score_pulse(score_pulse),
    .bird_tick(bird_tick), .pipe_tick(pipe_tick), .freeze(freeze), .game_clear(game_clear),
    .flash(flash), .state(state), .level(level)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic score(input int n);
    repeat (n) begin
      score_pulse = 1'b1;
      @(negedge clk);
      score_pulse = 1'b0;
      @(negedge clk);
    end
  endtask
  // cycles between two consecutive ticks; 40 means the tick never came
  task automatic measure(input bit pipe, output int period);
    int n = 0;
    while (!(pipe ? pipe_tick : bird_tick) && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pipe ? pipe_tick : bird_tick) && n < 40);
    period = n;
  endtask
  initial begin
    int p, nt;
    reset = 1'b1; flap = 1'b0; collision = 1'b0; score_pulse = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_freeze", freeze, 1);
    check("rst_clear", game_clear, 1);
    check("rst_bird", bird_tick, 0);
    check("rst_pipe", pipe_tick, 0);
    check("rst_flash", flash, 0);
    check("rst_level", level, 0);
    reset = 1'b0;
    @(negedge clk);
    check("clear_drop", game_clear, 0);
    check("idle_hold", state, 0);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    check("flap_delay", state, 0);
    @(negedge clk);
    check("play_state", state, 1);
    check("play_freeze", freeze, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("bird_win", bird_tick, int'(i % 4 == 3));
      check("pipe_win", pipe_tick, int'(i % 8 == 7));
    end
    score(2);
    check("level_2", level, L1);
    measure(1'b1, p);
    check("pipe_p_lvl1", p, P1);
    measure(1'b0, p);
    check("bird_p", p, 4);
    score(6);
    check("level_8", level, L4);
    measure(1'b1, p);
    check("pipe_p_floor", p, P4);
    score(6);
    check("level_14", level, L7);
    score(2);
    check("level_sat", level, L7);
    measure(1'b1, p);
    check("pipe_p_sat", p, P4);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("crash_state", state, 2);
      check("crash_flash", flash, int'(i % 2 == 0));
      check("crash_ticks", bird_tick | pipe_tick, 0);
      if (i == 1) flap = 1'b1;
      if (i == 2) flap = 1'b0;
    end
    @(negedge clk);
    check("over_state", state, 3);
    check("over_flash", flash, 1);
    @(negedge clk);
    check("over_hold", state, 3);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    check("over_noclear", game_clear, 0);
    check("over_wait", state, 3);
    @(negedge clk);
    check("gc_pulse", game_clear, 1);
    check("gc_idle", state, 0);
    @(negedge clk);
    check("gc_end", game_clear, 0);
    check("idle_again", state, 0);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    @(negedge clk);
    check("play2_state", state, 1);
    check("level_cleared", level, 0);
    score(1);
    check("level_sub1", level, 0);
    collision = 1'b1;
    score_pulse = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    score_pulse = 1'b0;
    check("prio_state", state, 2);
    check("prio_level", level, 0);
    nt = int'(bird_tick) + int'(pipe_tick);
    repeat (4) begin
      @(negedge clk);
      nt += int'(bird_tick) + int'(pipe_tick);
    end
    check("prio_noticks", nt, 0);
    check("prio_crash", state, 2);
    check("prio_flash", flash, 1);
    reset = 1'b1;
    #1;
    check("arst_crash_state", state, 0);
    check("arst_crash_flash", flash, 0);
    check("arst_crash_clear", game_clear, 1);
    @(negedge clk);
    reset = 1'b0;
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    @(negedge clk);
    check("play3_state", state, 1);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_bird", bird_tick, 1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_freeze", freeze, 1);
    check("arst_clear", game_clear, 1);
    check("arst_bird", bird_tick, 0);
    check("arst_pipe", pipe_tick, 0);
    check("arst_flash", flash, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
